// File: rtl/score_board_bcd.sv
// N-digit BCD score counter with high-score register, RUN/OVER game FSM and
// seven-segment pixel renderer. Optional milestone blink: define SCORE_BLINK_EN.
module score_board_bcd #(
  parameter int NUM_DIGITS   = 4,
  parameter int WRAP         = 1,
  parameter int LSD_X        = 590,
  parameter int TOP_Y        = 30,
  parameter int DIGIT_W      = 20,
  parameter int DIGIT_H      = 21,
  parameter int DIGIT_GAP    = 10,
  parameter int SEG_T        = 3,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             vgaX,
  input  logic [31:0]             vgaY,
  input  logic                    score_tick,
  input  logic                    game_start,
  input  logic                    game_over,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] hi_bcd,
  output logic                    new_hi,
  output logic                    inGrey
);

  // state | meaning
  // IDLE  | after reset, waiting for the first game_start
  // RUN   | game in progress, score_tick counts
  // OVER  | game ended, score frozen until game_start
  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam int SW = 4 * NUM_DIGITS;

  localparam logic signed [33:0] W_S   = 34'(DIGIT_W);
  localparam logic signed [33:0] H_S   = 34'(DIGIT_H);
  localparam logic signed [33:0] T_S   = 34'(SEG_T);
  localparam logic signed [33:0] M_S   = 34'((DIGIT_H - 1) / 2);
  localparam logic signed [33:0] HT_S  = 34'(SEG_T / 2);
  localparam logic signed [33:0] TOP_S = 34'(TOP_Y);

  state_t            state;
  logic [SW-1:0]     inc_score;
  logic [SW-1:0]     run_score;
  logic [NUM_DIGITS:0] carry;
  logic              enter_run;
  logic              hit;

  function automatic logic [6:0] seg_map(input logic [3:0] d);
    case (d)
      4'd0:    seg_map = 7'b1111110;
      4'd1:    seg_map = 7'b0110000;
      4'd2:    seg_map = 7'b1101101;
      4'd3:    seg_map = 7'b1111001;
      4'd4:    seg_map = 7'b0110011;
      4'd5:    seg_map = 7'b1011011;
      4'd6:    seg_map = 7'b1011111;
      4'd7:    seg_map = 7'b1110000;
      4'd8:    seg_map = 7'b1111111;
      4'd9:    seg_map = 7'b1111011;
      default: seg_map = 7'b0000000;
    endcase
  endfunction

  // Ripple-carry BCD increment; nibble 0 of score_bcd is the LSD.
  always_comb begin
    carry     = '0;
    carry[0]  = 1'b1;
    inc_score = score_bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (carry[k]) begin
        if (score_bcd[4*k +: 4] >= 4'd9) begin
          inc_score[4*k +: 4] = 4'd0;
          carry[k+1]          = 1'b1;
        end else begin
          inc_score[4*k +: 4] = score_bcd[4*k +: 4] + 4'd1;
        end
      end
    end
    if (carry[NUM_DIGITS] && (WRAP == 0)) inc_score = score_bcd;
  end

  assign run_score = score_tick ? inc_score : score_bcd;
  assign enter_run = game_start && (state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      score_bcd <= '0;
      hi_bcd    <= '0;
      new_hi    <= 1'b0;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (game_start) begin
            state     <= RUN;
            score_bcd <= '0;
            new_hi    <= 1'b0;
          end
        end
        RUN: begin
          score_bcd <= run_score;
          if (game_over) begin
            state <= OVER;
            // Valid BCD compares correctly as a plain unsigned vector.
            if (run_score > hi_bcd) begin
              hi_bcd <= run_score;
              new_hi <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    logic signed [33:0] lx;
    logic signed [33:0] ly;
    logic signed [33:0] dy;
    logic signed [33:0] left;
    logic [6:0]         seg;
    logic               in_box;
    hit    = 1'b0;
    lx     = '0;
    ly     = '0;
    dy     = '0;
    left   = '0;
    seg    = '0;
    in_box = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      left   = 34'(LSD_X - (NUM_DIGITS - 1 - i) * (DIGIT_W + DIGIT_GAP));
      lx     = $signed({2'b00, vgaX}) - left;
      ly     = $signed({2'b00, vgaY}) - TOP_S;
      dy     = ly - M_S;
      seg    = seg_map(score_bcd[4*(NUM_DIGITS-1-i) +: 4]);
      in_box = (lx >= 0) && (lx < W_S) && (ly >= 0) && (ly < H_S);
      if (in_box && (
            (seg[6] && (ly < T_S)) ||
            (seg[5] && (lx >= W_S - T_S) && (ly <= M_S)) ||
            (seg[4] && (lx >= W_S - T_S) && (ly >= M_S)) ||
            (seg[3] && (ly >= H_S - T_S)) ||
            (seg[2] && (lx < T_S) && (ly >= M_S)) ||
            (seg[1] && (lx < T_S) && (ly <= M_S)) ||
            (seg[0] && (dy >= -HT_S) && (dy <= HT_S))))
        hit = 1'b1;
    end
  end

`ifdef SCORE_BLINK_EN
  localparam int MS_IDX = (NUM_DIGITS >= 3) ? 2 : NUM_DIGITS;

  logic [31:0] blink_cnt;
  logic [3:0]  blink_win;
  logic        milestone;
  logic        blank;

  // A carry into the hundreds digit marks every 100 points.
  assign milestone = (NUM_DIGITS >= 3) && (state == RUN) && score_tick &&
                     carry[MS_IDX] && !((WRAP == 0) && carry[NUM_DIGITS]);
  assign blank     = (blink_win != 4'd0) && !blink_win[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_win <= '0;
    end else if (enter_run) begin
      blink_cnt <= '0;
      blink_win <= '0;
    end else if (milestone) begin
      blink_cnt <= 32'(BLINK_CYCLES - 1);
      blink_win <= 4'd8;
    end else if (blink_win != 4'd0) begin
      if (blink_cnt == 32'd0) begin
        blink_cnt <= 32'(BLINK_CYCLES - 1);
        blink_win <= blink_win - 4'd1;
      end else begin
        blink_cnt <= blink_cnt - 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inGrey <= 1'b0;
    else        inGrey <= hit && !blank;
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inGrey <= 1'b0;
    else        inGrey <= hit;
  end
`endif

endmodule

// File: tb/tb_score_board_bcd.sv
// Directed bench for score_board_bcd: game FSM, BCD counting, high score,
// wrap vs saturate, and seven-segment pixel hits.
module tb_score_board_bcd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] vgaX, vgaY;
  logic        score_tick, game_start, game_over;
  logic [15:0] score_bcd, hi_bcd, score_sat, hi_sat;
  logic        new_hi, new_hi_sat, in_grey, in_grey_sat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  score_board_bcd #(.NUM_DIGITS(4), .WRAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .vgaX(vgaX), .vgaY(vgaY),
    .score_tick(score_tick), .game_start(game_start), .game_over(game_over),
    .score_bcd(score_bcd), .hi_bcd(hi_bcd), .new_hi(new_hi), .inGrey(in_grey));

  score_board_bcd #(.NUM_DIGITS(4), .WRAP(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .vgaX(vgaX), .vgaY(vgaY),
    .score_tick(score_tick), .game_start(game_start), .game_over(game_over),
    .score_bcd(score_sat), .hi_bcd(hi_sat), .new_hi(new_hi_sat), .inGrey(in_grey_sat));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      score_tick = 1'b1;
      @(negedge clk);
    end
    score_tick = 1'b0;
  endtask

  task automatic start_pulse();
    game_start = 1'b1;
    @(negedge clk);
    game_start = 1'b0;
  endtask

  task automatic over_pulse();
    game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
  endtask

  task automatic pixel(input logic [31:0] x, input logic [31:0] y);
    vgaX = x;
    vgaY = y;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; vgaX = 32'd0; vgaY = 32'd0;
    score_tick = 1'b0; game_start = 1'b0; game_over = 1'b0;
    #2;
    check("rst_score", 32'(score_bcd), 32'h0);
    check("rst_hi", 32'(hi_bcd), 32'h0);
    check("rst_new_hi", 32'(new_hi), 32'h0);
    check("rst_in_grey", 32'(in_grey), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    tick(3);
    over_pulse();
    check("idle_ignore", 32'(score_bcd), 32'h0);

    start_pulse();
    tick(12);
    check("score_12", 32'(score_bcd), 32'h0012);
    check("new_hi_run", 32'(new_hi), 32'h0);
    check("hi_run", 32'(hi_bcd), 32'h0);
    start_pulse();
    check("start_in_run", 32'(score_bcd), 32'h0012);
    over_pulse();
    check("g1_hi", 32'(hi_bcd), 32'h0012);
    check("g1_new_hi", 32'(new_hi), 32'h1);
    tick(5);
    over_pulse();
    check("over_ignore", 32'(score_bcd), 32'h0012);
    check("over_hi_keep", 32'(hi_bcd), 32'h0012);

    start_pulse();
    check("g2_clear", 32'(score_bcd), 32'h0);
    check("g2_new_hi_clr", 32'(new_hi), 32'h0);
    tick(41);
    check("score_41", 32'(score_bcd), 32'h0041);
    score_tick = 1'b1; game_over = 1'b1;
    @(negedge clk);
    score_tick = 1'b0; game_over = 1'b0;
    check("tick_over_score", 32'(score_bcd), 32'h0042);
    check("tick_over_hi", 32'(hi_bcd), 32'h0042);
    check("tick_over_new_hi", 32'(new_hi), 32'h1);
    tick(2);
    check("over_frozen", 32'(score_bcd), 32'h0042);

    start_pulse();
    check("g3_new_hi_clr", 32'(new_hi), 32'h0);
    check("g3_hi_keep", 32'(hi_bcd), 32'h0042);
    tick(5);
    over_pulse();
    check("low_hi", 32'(hi_bcd), 32'h0042);
    check("low_new_hi", 32'(new_hi), 32'h0);

    start_pulse();
    tick(42);
    over_pulse();
    check("equal_new_hi", 32'(new_hi), 32'h0);
    check("equal_hi", 32'(hi_bcd), 32'h0042);

    start_pulse();
    tick(8);
    pixel(32'd585, 32'd40);
    check("pix_gap", 32'(in_grey), 32'h0);
    vgaX = 32'd600; vgaY = 32'd40;
    #1;
    check("pix_latency", 32'(in_grey), 32'h0);
    @(negedge clk);
    check("pix_8_mid", 32'(in_grey), 32'h1);
    pixel(32'd600, 32'd29);
    check("pix_above", 32'(in_grey), 32'h0);
    pixel(32'd600, 32'd30);
    check("pix_8_top", 32'(in_grey), 32'h1);
    pixel(32'd560, 32'd40);
    check("pix_0_left", 32'(in_grey), 32'h1);
    pixel(32'd570, 32'd40);
    check("pix_0_mid", 32'(in_grey), 32'h0);
    pixel(32'hFFFF_FFFF, 32'd40);
    check("pix_far", 32'(in_grey), 32'h0);
    over_pulse();

    start_pulse();
    tick(1);
    pixel(32'd600, 32'd40);
    check("pix_1_mid", 32'(in_grey), 32'h0);
    pixel(32'd609, 32'd35);
    check("pix_1_b", 32'(in_grey), 32'h1);
    pixel(32'd0, 32'd0);
    over_pulse();

    start_pulse();
    tick(9999);
    check("wrap_9999", 32'(score_bcd), 32'h9999);
    check("sat_9999", 32'(score_sat), 32'h9999);
    tick(1);
    check("wrap_roll", 32'(score_bcd), 32'h0000);
    check("sat_hold", 32'(score_sat), 32'h9999);
    over_pulse();
    check("wrap_hi", 32'(hi_bcd), 32'h0042);
    check("sat_hi", 32'(hi_sat), 32'h9999);
    check("sat_new_hi", 32'(new_hi_sat), 32'h1);

    start_pulse();
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_score", 32'(score_bcd), 32'h0);
    check("midrun_rst_hi", 32'(hi_sat), 32'h0);
    check("midrun_rst_new_hi", 32'(new_hi_sat), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
